// File: rtl/single_port_ram_if.sv
// Request/response bus of the single-port RAM: req/gnt handshake plus a
// registered read-data response.
interface single_port_ram_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    req_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic                    we_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic                    gnt_o;
   logic                    rvalid_o;
   logic [DATA_WIDTH-1:0]   rdata_o;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/single_port_ram.sv
// Single-port word RAM with byte enables. Every request is granted at once
// and answered exactly one cycle later; contents survive reset.
module single_port_ram #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   single_port_ram_if.slave  bus
);
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam int unsigned MEM_AW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic [31:0]           idx_ext;
   logic [MEM_AW-1:0]     mem_idx;
   logic                  in_range;
   logic                  rd_en;
   logic                  wr_en;

   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

   // Word index is widened to 32 bits so the range check works for any
   // ADDR_WIDTH / NUM_WORDS combination, then narrowed to the array index.
   assign idx_ext  = 32'(bus.addr_i[ADDR_WIDTH-1:2]);
   assign in_range = (idx_ext < NUM_WORDS);
   assign mem_idx  = MEM_AW'(idx_ext);

   assign rd_en = bus.req_i & ~bus.we_i;
   assign wr_en = bus.req_i &  bus.we_i & in_range & rst_n;

   assign bus.gnt_o = bus.req_i;

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
         if (wr_en && bus.be_i[k]) begin
            mem[mem_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      rvalid_d = bus.req_i;
      rdata_d  = rdata_q;
      if (rd_en) begin
         rdata_d = in_range ? mem[mem_idx] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_single_port_ram.sv
// Directed, table-driven bench for single_port_ram: one vector per cycle with
// hand-computed response, plus hand-written reset sequences.
module tb_single_port_ram;
   logic clk;
   logic rst_n;

   single_port_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   single_port_ram #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .NUM_WORDS (256)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs[$];
   int          n_vec;
   int          n_bad;
   logic [31:0] hold;
   logic [31:0] preload [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic req, input logic we, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic exp_rvalid, input logic [31:0] exp_rdata);
      vec_t v;
      v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata;
      vecs.push_back(v);
      hold = exp_rdata;
   endtask

   task automatic drive(input logic req, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      bus.req_i   = req;
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.wdata_i = wdata;
      bus.be_i    = be;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

      for (int i = 0; i < 64; i++) preload[i] = 32'h1000_0000 | 32'(i);
      preload[32] = 32'h0000_0013;
      for (int i = 0; i < 64; i++) dut.mem[i] <= preload[i];

      // ---- vector table ----
      hold = 32'h0;
      add(1, 0, 8'h80, 32'h0, 4'b0001, 1, 32'h0000_0013);
      // Sequential reads with idle cycles carrying junk write attempts
      for (int a = 8'h80; a <= 8'hFC; a += 4) begin
         add(1, 0, 8'(a), 32'h0, 4'hF, 1, preload[a >> 2]);
         add(0, 1, 8'(a), 32'hDEAD_DEAD, 4'hF, 0, hold);
      end
      for (int a = 8'hCC; a <= 8'hFC; a += 4) add(1, 1, 8'(a), 32'h0000_BEEF, 4'hF, 1, hold);
      for (int a = 8'hCC; a <= 8'hFC; a += 4) add(1, 0, 8'(a), 32'h0, 4'h0, 1, 32'h0000_BEEF);
      // Partial and zero-enable writes
      add(1, 1, 8'h40, 32'h1234_5678, 4'b1111, 1, hold);
      add(1, 1, 8'h40, 32'hAABB_CCDD, 4'b0101, 1, hold);
      add(1, 0, 8'h40, 32'h0,         4'b0000, 1, 32'h12BB_56DD);
      add(1, 1, 8'h40, 32'hFFFF_FFFF, 4'b0000, 1, hold);
      add(1, 0, 8'h40, 32'h0,         4'b0000, 1, 32'h12BB_56DD);
      // Back-to-back write then read; low address bits ignored
      add(1, 1, 8'h10, 32'hCAFE_F00D, 4'hF, 1, hold);
      add(1, 0, 8'h10, 32'h0,         4'h0, 1, 32'hCAFE_F00D);
      add(1, 0, 8'h13, 32'h0,         4'h0, 1, 32'hCAFE_F00D);
      add(1, 0, 8'h40, 32'h0,         4'h0, 1, 32'h12BB_56DD);
      add(0, 0, 8'h00, 32'h0,         4'h0, 0, 32'h12BB_56DD);

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("reset_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("reset_rdata",  bus.rdata_o,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- table ----
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         #1;
         check($sformatf("gnt[%0d]", i), 32'(bus.gnt_o), 32'(vecs[i].req));
         @(posedge clk);
         #1;
         check($sformatf("rvalid[%0d]", i), 32'(bus.rvalid_o), 32'(vecs[i].exp_rvalid));
         check($sformatf("rdata[%0d]", i),  bus.rdata_o,       vecs[i].exp_rdata);
      end

      // ---- write right before reset persists; reset mid-read is immediate ----
      @(negedge clk);
      drive(1, 1, 8'h20, 32'h5A5A_5A5A, 4'hF);
      @(negedge clk);
      drive(1, 0, 8'hCC, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      check("pre_rst_rdata", bus.rdata_o, 32'h0000_BEEF);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("async_rst_rdata",  bus.rdata_o,       32'h0);
      check("gnt_in_reset",     32'(bus.gnt_o),    32'h1);
      @(posedge clk);
      #1;
      check("inflight_dropped", 32'(bus.rvalid_o), 32'h0);
      @(negedge clk);
      drive(0, 0, 8'h00, 32'h0, 4'h0);
      #1;
      check("gnt_idle_reset", 32'(bus.gnt_o), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("post_rst_rdata",  bus.rdata_o,       32'h0);
      @(negedge clk);
      drive(1, 0, 8'hCC, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      check("persist_rvalid", 32'(bus.rvalid_o), 32'h1);
      check("persist_beef",   bus.rdata_o,       32'h0000_BEEF);
      @(negedge clk);
      drive(1, 0, 8'h20, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      check("persist_5a", bus.rdata_o, 32'h5A5A_5A5A);
      @(negedge clk);
      drive(0, 0, 8'h00, 32'h0, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end
endmodule
